// File: rtl/lcd_refresh_ctrl_if.sv
// LCD pin bundle (rs/rw/en/data) driven by lcd_refresh_ctrl toward an HD44780 panel.
interface lcd_refresh_ctrl_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, lcd_rw, lcd_en, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_data);
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 sequencer: power-up delay, init commands, then periodic two-line refresh.
// Optional macro LCD_REFRESH_SKIP_EN: skip a refresh frame when the text has not changed.
//
// state      | meaning
// POWERUP    | bus idle, waiting INIT_WAIT_CYCLES after reset
// INIT       | commands 0x38, 0x0C, 0x06, 0x01 (clear uses the long settle)
// ADDR1      | set DDRAM address to line 1 (0x80); text snapshot taken on entry
// LINE1      | 16 chars from reg_a..reg_d snapshot
// ADDR2      | set DDRAM address to line 2 (0xC0)
// LINE2      | 16 chars from reg_e..reg_h snapshot
// GAP        | idle REFRESH_CYCLES between frames
module lcd_refresh_ctrl #(
  parameter int unsigned EN_CYCLES         = 25,
  parameter int unsigned WAIT_CYCLES       = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000,
  parameter int unsigned INIT_WAIT_CYCLES  = 1000000,
  parameter int unsigned REFRESH_CYCLES    = 500000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        reg_a,
  input  logic [31:0]        reg_b,
  input  logic [31:0]        reg_c,
  input  logic [31:0]        reg_d,
  input  logic [31:0]        reg_e,
  input  logic [31:0]        reg_f,
  input  logic [31:0]        reg_g,
  input  logic [31:0]        reg_h,
  lcd_refresh_ctrl_if.master lcd,
  output logic               init_done,
  output logic               frame_done
);

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_GAP
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE, PH_WAIT, PH_SETUP, PH_STROBE, PH_SETTLE
  } phase_t;

  state_t       state_q, state_d;
  phase_t       phase_q, phase_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic         rs_q, rs_d;
  logic         en_q, en_d;
  logic [7:0]   data_q, data_d;
  logic         init_done_q, init_done_d;
  logic         frame_done_q, frame_done_d;
  logic [255:0] snap_q, snap_d;
  logic [255:0] live;
  logic         start;
  logic         skip;
  logic [127:0] line_sel;
  logic [127:0] line_shift;

  assign live = {reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h};

`ifdef LCD_REFRESH_SKIP_EN
  assign skip = (live == snap_q);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rs_d         = rs_q;
    data_d       = data_q;
    en_d         = 1'b0;
    snap_d       = snap_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    start        = 1'b0;

    case (phase_q)
      // First cycle after reset already counts toward the power-up delay.
      PH_IDLE: begin
        state_d = ST_POWERUP;
        idx_d   = '0;
        if (INIT_WAIT_CYCLES > 1) begin
          phase_d = PH_WAIT;
          cnt_d   = INIT_WAIT_CYCLES - 2;
        end else begin
          state_d = ST_INIT;
          start   = 1'b1;
        end
      end
      PH_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (state_q == ST_POWERUP) begin
          state_d = ST_INIT;
          idx_d   = '0;
          start   = 1'b1;
        end else if (skip) begin
          cnt_d = REFRESH_CYCLES - 1;
        end else begin
          state_d = ST_ADDR1;
          idx_d   = '0;
          snap_d  = live;
          start   = 1'b1;
        end
      end
      PH_SETUP: begin
        phase_d = PH_STROBE;
        cnt_d   = EN_CYCLES - 1;
        en_d    = 1'b1;
      end
      PH_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
          en_d  = 1'b1;
        end else begin
          phase_d = PH_SETTLE;
          cnt_d   = (state_q == ST_INIT && idx_q == 4'd3) ? CLEAR_WAIT_CYCLES - 1
                                                          : WAIT_CYCLES - 1;
        end
      end
      PH_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          start = 1'b1;
          idx_d = idx_q + 4'd1;
          case (state_q)
            ST_INIT: begin
              if (idx_q == 4'd3) begin
                state_d     = ST_ADDR1;
                idx_d       = '0;
                snap_d      = live;
                init_done_d = 1'b1;
              end
            end
            ST_ADDR1: begin
              state_d = ST_LINE1;
              idx_d   = '0;
            end
            ST_LINE1: begin
              if (idx_q == 4'd15) begin
                state_d = ST_ADDR2;
                idx_d   = '0;
              end
            end
            ST_ADDR2: begin
              state_d = ST_LINE2;
              idx_d   = '0;
            end
            ST_LINE2: begin
              if (idx_q == 4'd15) begin
                state_d      = ST_GAP;
                phase_d      = PH_WAIT;
                idx_d        = '0;
                cnt_d        = REFRESH_CYCLES - 1;
                frame_done_d = 1'b1;
                start        = 1'b0;
              end
            end
            default: begin
              state_d = ST_POWERUP;
              phase_d = PH_IDLE;
              idx_d   = '0;
              start   = 1'b0;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_POWERUP;
        phase_d = PH_IDLE;
      end
    endcase

    // rs/data are loaded only when a transaction enters SETUP.
    line_sel   = (state_d == ST_LINE1) ? snap_q[255:128] : snap_q[127:0];
    line_shift = line_sel << {idx_d, 3'b000};
    if (start) begin
      phase_d = PH_SETUP;
      rs_d    = 1'b0;
      case (state_d)
        ST_INIT: begin
          case (idx_d)
            4'd0:    data_d = 8'h38;
            4'd1:    data_d = 8'h0C;
            4'd2:    data_d = 8'h06;
            default: data_d = 8'h01;
          endcase
        end
        ST_ADDR1: data_d = 8'h80;
        ST_ADDR2: data_d = 8'hC0;
        ST_LINE1, ST_LINE2: begin
          rs_d   = 1'b1;
          data_d = line_shift[127:120];
        end
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_POWERUP;
      phase_q      <= PH_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      snap_q       <= snap_d;
    end
  end

  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_en   = en_q;
  assign lcd.lcd_data = data_q;
  assign init_done    = init_done_q;
  assign frame_done   = frame_done_q;

endmodule
